// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   tx_state_t     - transmitter frame states
//   STOP_MODE_*    - encodings of the stop-bit mode input
//   DATA_BITS      - data bits per frame
//   data_bit_index - maps a data-bit counter to a word bit position
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Stop-bit mode encodings. The STOP_MODE_ prefix keeps them apart from the
  // STOP_2 state name below.
  localparam logic [1:0] STOP_MODE_1   = 2'b00;
  localparam logic [1:0] STOP_MODE_1_5 = 2'b01;
  localparam logic [1:0] STOP_MODE_2   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP_2
  } tx_state_t;

  // Converts the count of data bits already sent into the word bit to send.
  // LSB-first walks 0..7, MSB-first walks 7..0.
  function automatic logic [2:0] data_bit_index(input logic [3:0] bit_cnt,
                                                input logic       msb_first);
    logic [3:0] idx;
    idx = msb_first ? (4'(DATA_BITS - 1) - bit_cnt) : bit_cnt;
    return idx[2:0];
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: loadable down-counter that measures one bit period.
//   i_clk          - clock, rising edge
//   i_nrst         - asynchronous active-low reset
//   i_load         - load i_load_value this cycle (takes priority)
//   i_load_value   - value to load; a period lasts i_load_value+1 cycles
//   o_period_done  - high while the counter sits at zero
// The count holds at zero until reloaded, so a caller that reloads on every
// o_period_done sees it as a one-cycle pulse per period.
module uart_bit_timer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_period_done
);

  logic [WIDTH-1:0] count;

  // Count down towards zero; a load restarts the period.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign o_period_done = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends start bit, 8 data bits, even parity and
// 1 / 1.5 / 2 stop bits, each bit lasting the latched bit length L.
//   i_clk, i_nrst              - clock and asynchronous active-low reset
//   i_bit_length               - clocks per bit (0 behaves as 1)
//   i_hw_flow_control_enable   - when set, frames start only while i_cts=1
//   i_msb_first                - send bit 7 first when set
//   i_stop_bit_mode            - 00: 1 stop, 01: 1.5 stop, 10/11: 2 stop
//   i_tx_valid, i_tx_word      - word offered by the TX FIFO
//   o_tx_ready                 - word accepted this cycle if valid
//   o_tx_started               - pulse on the first start-bit cycle
//   o_tx_done                  - pulse in the first IDLE cycle after a frame
//   o_tx_busy                  - frame in progress
//   i_cts                      - clear-to-send from the peer
//   o_tx                       - registered serial output, idle high
module uart_tx
  import uart_pkg::*;
#(
  parameter int BIT_LEN_W = 32
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic [BIT_LEN_W-1:0] i_bit_length,
  input  logic                 i_hw_flow_control_enable,
  input  logic                 i_msb_first,
  input  logic [1:0]           i_stop_bit_mode,
  input  logic                 i_tx_valid,
  input  logic [7:0]           i_tx_word,
  output logic                 o_tx_ready,
  output logic                 o_tx_started,
  output logic                 o_tx_done,
  output logic                 o_tx_busy,
  input  logic                 i_cts,
  output logic                 o_tx
);

  tx_state_t            state;
  tx_state_t            state_next;
  logic [3:0]           bit_cnt;
  logic [3:0]           bit_cnt_next;
  logic                 tx_next;
  logic                 started_next;
  logic                 done_next;

  logic [7:0]           word_q;
  logic                 parity_q;
  logic [BIT_LEN_W-1:0] len_q;
  logic                 msb_q;
  logic [1:0]           stop_q;

  logic                 accept;
  logic [BIT_LEN_W-1:0] eff_len;
  logic [BIT_LEN_W-1:0] half_raw;
  logic [BIT_LEN_W-1:0] half_len;
  logic                 timer_load;
  logic [BIT_LEN_W-1:0] timer_load_value;
  logic                 period_done;

  // Ready is gated by the reset input so it reads 0 while held in reset.
  assign o_tx_ready = i_nrst && (state == IDLE) &&
                      (i_hw_flow_control_enable ? i_cts : 1'b1);
  assign accept     = i_tx_valid && o_tx_ready;
  assign o_tx_busy  = (state != IDLE);

  assign eff_len  = (i_bit_length == '0) ? BIT_LEN_W'(1) : i_bit_length;
  assign half_raw = len_q >> 1;
  assign half_len = (half_raw == '0) ? BIT_LEN_W'(1) : half_raw;

  uart_bit_timer #(
    .WIDTH (BIT_LEN_W)
  ) u_bit_timer (
    .i_clk         (i_clk),
    .i_nrst        (i_nrst),
    .i_load        (timer_load),
    .i_load_value  (timer_load_value),
    .o_period_done (period_done)
  );

  // Frame sequencing. The serial line is registered, so each transition
  // computes the level of the bit being entered; the timer is reloaded at
  // every bit boundary so every bit lasts exactly L clocks.
  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    tx_next          = o_tx;
    started_next     = 1'b0;
    done_next        = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = len_q - 1'b1;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          state_next       = START;
          tx_next          = 1'b0;
          started_next     = 1'b1;
          timer_load       = 1'b1;
          timer_load_value = eff_len - 1'b1;
        end
      end

      START: begin
        if (period_done) begin
          state_next   = DATA;
          bit_cnt_next = 4'd0;
          tx_next      = word_q[data_bit_index(4'd0, msb_q)];
          timer_load   = 1'b1;
        end
      end

      DATA: begin
        if (period_done) begin
          timer_load = 1'b1;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            state_next = PARITY;
            tx_next    = parity_q;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
            tx_next      = word_q[data_bit_index(bit_cnt + 4'd1, msb_q)];
          end
        end
      end

      PARITY: begin
        if (period_done) begin
          state_next = STOP;
          tx_next    = 1'b1;
          timer_load = 1'b1;
        end
      end

      STOP: begin
        if (period_done) begin
          tx_next = 1'b1;
          if (stop_q == STOP_MODE_1) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = STOP_2;
            timer_load = 1'b1;
            if (stop_q == STOP_MODE_1_5) begin
              timer_load_value = half_len - 1'b1;
            end
          end
        end
      end

      STOP_2: begin
        if (period_done) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State, serial line and status pulses.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= IDLE;
      bit_cnt      <= 4'd0;
      o_tx         <= 1'b1;
      o_tx_started <= 1'b0;
      o_tx_done    <= 1'b0;
    end else begin
      state        <= state_next;
      bit_cnt      <= bit_cnt_next;
      o_tx         <= tx_next;
      o_tx_started <= started_next;
      o_tx_done    <= done_next;
    end
  end

  // Frame parameters are captured on accept so later input changes cannot
  // disturb a frame in flight. Mode 11 is folded into the 2-stop encoding.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      word_q   <= 8'd0;
      parity_q <= 1'b0;
      len_q    <= '0;
      msb_q    <= 1'b0;
      stop_q   <= STOP_MODE_1;
    end else if (accept) begin
      word_q   <= i_tx_word;
      parity_q <= ^i_tx_word;
      len_q    <= eff_len;
      msb_q    <= i_msb_first;
      stop_q   <= ((i_stop_bit_mode == STOP_MODE_1) ||
                   (i_stop_bit_mode == STOP_MODE_1_5)) ? i_stop_bit_mode
                                                       : STOP_MODE_2;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. The driver pushes the expected
// frame (hand-written bit order, parity, bit length and stop length) when a
// word is accepted; the monitor pops it on o_tx_started and walks the line.
module tb_uart_tx;

  logic        i_clk = 1'b0;
  logic        i_nrst = 1'b0;
  logic [31:0] i_bit_length;
  logic        i_hw_flow_control_enable;
  logic        i_msb_first;
  logic [1:0]  i_stop_bit_mode;
  logic        i_tx_valid;
  logic [7:0]  i_tx_word;
  logic        o_tx_ready;
  logic        o_tx_started;
  logic        o_tx_done;
  logic        o_tx_busy;
  logic        i_cts;
  logic        o_tx;

  typedef struct {
    int         id;
    logic [7:0] exp_seq;   // bit i = level of the i-th data bit on the line
    logic       exp_par;
    int         len;
    int         stop_clks;
    bit         abort;
    time        acc_time;
  } frame_t;

  frame_t sb_q[$];
  int     checks_total  = 0;
  int     checks_passed = 0;
  int     frame_id      = 0;
  bit     mon_active    = 1'b0;

  uart_tx #(
    .BIT_LEN_W (32)
  ) dut (
    .i_clk                    (i_clk),
    .i_nrst                   (i_nrst),
    .i_bit_length             (i_bit_length),
    .i_hw_flow_control_enable (i_hw_flow_control_enable),
    .i_msb_first              (i_msb_first),
    .i_stop_bit_mode          (i_stop_bit_mode),
    .i_tx_valid               (i_tx_valid),
    .i_tx_word                (i_tx_word),
    .o_tx_ready               (o_tx_ready),
    .o_tx_started             (o_tx_started),
    .o_tx_done                (o_tx_done),
    .o_tx_busy                (o_tx_busy),
    .i_cts                    (i_cts),
    .o_tx                     (o_tx)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Offers one word and waits (bounded) for it to be accepted, then pushes
  // the expected frame. Returns the accept edge time and cycles waited.
  task automatic applyStimulus(input logic [7:0] word, input logic [31:0] len_in,
                               input logic msb_in, input logic [1:0] mode_in,
                               input logic cts_in, input logic [7:0] exp_seq,
                               input logic exp_par, input int eff_len,
                               input int stop_clks, input bit abort,
                               output time acc_time, output int waited);
    frame_t it;
    bit     found;
    found  = 1'b0;
    waited = 0;
    @(negedge i_clk);
    i_tx_word       = word;
    i_bit_length    = len_in;
    i_msb_first     = msb_in;
    i_stop_bit_mode = mode_in;
    i_cts           = cts_in;
    i_tx_valid      = 1'b1;
    for (int c = 0; c < 500; c++) begin
      #1;
      if (o_tx_ready) begin
        found = 1'b1;
        break;
      end
      waited++;
      @(negedge i_clk);
    end
    acc_time = 0;
    if (!found) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge i_clk);
      acc_time     = $time;
      it.id        = frame_id;
      it.exp_seq   = exp_seq;
      it.exp_par   = exp_par;
      it.len       = eff_len;
      it.stop_clks = stop_clks;
      it.abort     = abort;
      it.acc_time  = acc_time;
      sb_q.push_back(it);
      frame_id++;
    end
  endtask

  task automatic dropValid();
    @(negedge i_clk);
    i_tx_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge i_clk);
      if (!o_tx_busy && sb_q.size() == 0 && !mon_active) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    @(negedge i_clk);
  endtask

  // Walks one frame from its first start-bit sample: every bit must hold its
  // level for exactly len clocks with busy high, then the stop period, then
  // the done pulse with the line high.
  task automatic checkFrame(input frame_t it);
    int   bad;
    logic lvl;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      lvl = 1'b0;
      else if (b == 9) lvl = it.exp_par;
      else             lvl = it.exp_seq[b-1];
      bad = 0;
      for (int k = 0; k < it.len; k++) begin
        if (b != 0 || k != 0) @(negedge i_clk);
        if (o_tx !== lvl || o_tx_busy !== 1'b1 || o_tx_done !== 1'b0) bad++;
      end
      checkOutput($sformatf("f%0d_bit%0d_bad_samples", it.id, b), 32'(bad), 32'd0);
    end
    bad = 0;
    for (int k = 0; k < it.stop_clks; k++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1 || o_tx_busy !== 1'b1 || o_tx_done !== 1'b0) bad++;
    end
    checkOutput($sformatf("f%0d_stop_bad_samples", it.id), 32'(bad), 32'd0);
    @(negedge i_clk);
    checkOutput($sformatf("f%0d_done_tx_busy", it.id),
                {29'd0, o_tx_done, o_tx, o_tx_busy}, 32'b110);
  endtask

  // Monitor: pops the scoreboard whenever the DUT announces a frame start.
  initial begin
    frame_t it;
    bit     low_seen;
    forever begin
      @(negedge i_clk);
      if (o_tx_started === 1'b1) begin
        mon_active = 1'b1;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_start", 32'd1, 32'd0);
        end else begin
          it = sb_q.pop_front();
          checkOutput($sformatf("f%0d_start_latency", it.id),
                      32'($time - it.acc_time), 32'd5);
          if (it.abort) begin
            low_seen = 1'b0;
            for (int c = 0; c < 200; c++) begin
              @(negedge i_clk);
              if (!o_tx_busy) begin
                low_seen = 1'b1;
                break;
              end
            end
            checkOutput($sformatf("f%0d_abort_seen", it.id), 32'(low_seen), 32'd1);
          end else begin
            checkFrame(it);
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  // Directed sequence.
  initial begin
    time acc1;
    time acc2;
    int  waited;
    int  bad;

    i_bit_length             = 32'd4;
    i_hw_flow_control_enable = 1'b0;
    i_msb_first              = 1'b0;
    i_stop_bit_mode          = 2'b00;
    i_tx_valid               = 1'b0;
    i_tx_word                = 8'h00;
    i_cts                    = 1'b0;

    #12;
    checkOutput("reset_tx", 32'(o_tx), 32'd1);
    checkOutput("reset_ready", 32'(o_tx_ready), 32'd0);
    checkOutput("reset_started", 32'(o_tx_started), 32'd0);
    checkOutput("reset_done", 32'(o_tx_done), 32'd0);
    checkOutput("reset_busy", 32'(o_tx_busy), 32'd0);
    @(negedge i_clk);
    i_nrst = 1'b1;

    // L=4 LSB-first and MSB-first A5, then MSB-first 0F at L=3
    applyStimulus(8'hA5, 32'd4, 1'b0, 2'b00, 1'b0, 8'hA5, 1'b0, 4, 4, 1'b0, acc1, waited);
    dropValid(); waitIdle();
    applyStimulus(8'hA5, 32'd4, 1'b1, 2'b00, 1'b0, 8'hA5, 1'b0, 4, 4, 1'b0, acc1, waited);
    dropValid(); waitIdle();
    applyStimulus(8'h0F, 32'd3, 1'b1, 2'b00, 1'b0, 8'hF0, 1'b0, 3, 3, 1'b0, acc1, waited);
    dropValid(); waitIdle();

    // Stop modes: 2 stop at L=3, 1.5 at L=4, 1.5 at L=1 (half clamps to 1)
    applyStimulus(8'h07, 32'd3, 1'b0, 2'b10, 1'b0, 8'h07, 1'b1, 3, 6, 1'b0, acc1, waited);
    dropValid(); waitIdle();
    applyStimulus(8'h3C, 32'd4, 1'b0, 2'b01, 1'b0, 8'h3C, 1'b0, 4, 6, 1'b0, acc1, waited);
    dropValid(); waitIdle();
    applyStimulus(8'h80, 32'd1, 1'b0, 2'b01, 1'b0, 8'h80, 1'b1, 1, 2, 1'b0, acc1, waited);
    dropValid(); waitIdle();

    // Flow control: held off while CTS low, accepted as soon as it rises
    @(negedge i_clk);
    i_hw_flow_control_enable = 1'b1;
    i_cts        = 1'b0;
    i_tx_word    = 8'h96;
    i_bit_length = 32'd4;
    i_msb_first  = 1'b0;
    i_stop_bit_mode = 2'b00;
    i_tx_valid   = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      #1;
      if (o_tx_ready !== 1'b0 || o_tx !== 1'b1 || o_tx_busy !== 1'b0) bad++;
    end
    checkOutput("cts_blocked_bad_samples", 32'(bad), 32'd0);
    applyStimulus(8'h96, 32'd4, 1'b0, 2'b00, 1'b1, 8'h96, 1'b0, 4, 4, 1'b0, acc1, waited);
    checkOutput("cts_accept_wait", 32'(waited), 32'd0);
    @(negedge i_clk);
    i_tx_valid = 1'b0;
    i_cts      = 1'b0;
    waitIdle();
    i_hw_flow_control_enable = 1'b0;

    // Back-to-back with valid held; bit length change lands on word two only
    applyStimulus(8'h55, 32'd2, 1'b0, 2'b00, 1'b0, 8'h55, 1'b0, 2, 2, 1'b0, acc1, waited);
    applyStimulus(8'h0F, 32'd5, 1'b0, 2'b00, 1'b0, 8'h0F, 1'b0, 5, 5, 1'b0, acc2, waited);
    checkOutput("b2b_accept_spacing", 32'(acc2 - acc1), 32'd230);
    dropValid(); waitIdle();

    // Bit length 0 behaves as 1
    applyStimulus(8'h01, 32'd0, 1'b0, 2'b00, 1'b0, 8'h01, 1'b1, 1, 1, 1'b0, acc1, waited);
    dropValid(); waitIdle();

    // Reset during DATA: line high at once, busy clears, no done pulse
    applyStimulus(8'hFF, 32'd4, 1'b0, 2'b00, 1'b0, 8'hFF, 1'b0, 4, 4, 1'b1, acc1, waited);
    dropValid();
    repeat (7) @(negedge i_clk);
    #2;
    i_nrst = 1'b0;
    #1;
    checkOutput("mid_reset_tx_busy", {30'd0, o_tx, o_tx_busy}, 32'b10);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (c == 2) i_nrst = 1'b1;
      if (o_tx_done !== 1'b0 || o_tx !== 1'b1) bad++;
    end
    checkOutput("mid_reset_no_done", 32'(bad), 32'd0);
    waitIdle();

    // Clean frame after the reset, mode 11 treated as 2 stop bits
    applyStimulus(8'hC3, 32'd2, 1'b0, 2'b11, 1'b0, 8'hC3, 1'b0, 2, 4, 1'b0, acc1, waited);
    dropValid(); waitIdle();

    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. It serialises one 8-bit word per frame onto the TX line: start bit, 8 data bits, even parity bit, then 1, 1.5 or 2 stop bits. The frame format matches uart_rx exactly, so a uart_tx/uart_rx pair interoperates. It sits between the TX FIFO (valid/ready) and the pad, and honours CTS when hardware flow control is enabled.

Parameters:
BIT_LEN_W, 32, width of i_bit_length and of the internal bit-period counter.

Ports:
i_clk  input  1  clock, rising edge.
i_nrst  input  1  asynchronous active-low reset.
i_bit_length  input  BIT_LEN_W  clocks per bit; 0 is treated as 1.
i_hw_flow_control_enable  input  1  1 = frames start only while i_cts=1.
i_msb_first  input  1  1 = data bit 7 sent first; 0 = bit 0 sent first.
i_stop_bit_mode  input  2  00 = 1 stop bit, 01 = 1.5 stop bits, 10/11 = 2 stop bits.
i_tx_valid  input  1  word available from FIFO.
i_tx_word  input  8  data word.
o_tx_ready  output  1  transmitter accepts a word this cycle.
o_tx_started  output  1  one-cycle pulse on the first start-bit cycle.
o_tx_done  output  1  one-cycle pulse after the last stop bit completes.
o_tx_busy  output  1  frame in progress (any state other than IDLE).
i_cts  input  1  clear-to-send from the peer, active high.
o_tx  output  1  serial line, idle high, registered.

Behaviour:
- Reset values: o_tx=1, o_tx_ready=0, o_tx_started=0, o_tx_done=0, o_tx_busy=0, state=IDLE, all counters 0.
- o_tx_ready = (state==IDLE) && (i_hw_flow_control_enable ? i_cts : 1). It is combinational from state and i_cts.
- Accept: i_tx_valid && o_tx_ready at cycle N.
  - The following are latched at cycle N: word, parity (^word, even), bit length (max(i_bit_length,1)), msb_first, stop mode.
  - Input changes later in the frame have no effect on that frame.
- o_tx drives low starting at cycle N+1; o_tx_started pulses at N+1.
- States and transitions:
  - IDLE: on accept, go to START.
  - START: go to DATA after L cycles.
  - DATA: holds for 8 bit periods, then goes to PARITY.
  - PARITY: go to STOP after L cycles.
  - STOP: go to IDLE after L cycles in 1-stop mode; otherwise go to STOP_2.
  - STOP_2: lasts floor(L/2) cycles (minimum 1) in 1.5 mode and L cycles in 2-stop mode, then goes to IDLE.
  - L is the latched bit length.
- Each bit holds o_tx stable for exactly L clocks, with no jitter.
- Bit index:
  - LSB-first mode counts 0→7; MSB-first mode counts 7→0.
  - Use a 4-bit index and stop at 8 data bits; no wrap into the parity position.
- o_tx_done pulses in the first IDLE cycle after the final stop bit. o_tx is high in that cycle.
- Minimum inter-frame gap is one IDLE clock. Back-to-back frames are therefore separated by one extra high cycle.
- Frame length in clocks: 11·L for 1 stop bit, 11·L + floor(L/2) for 1.5, 12·L for 2.
- CTS is sampled only in IDLE. Deassertion mid-frame does not abort the frame.
- Reset mid-frame: asynchronously forces o_tx=1 and state=IDLE. The frame is lost, with no done pulse.
- The bit-period counter is 32-bit down-counting, loaded with L-1 at each bit boundary. A bit completes when the counter reaches 0.

Decomposition:
- uart_pkg additions:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP, STOP_2}.
  - Stop-mode constants STOP_1=2'b00, STOP_1_5=2'b01, STOP_2=2'b10.
  - Shared DATA_BITS=8.
- One sub-module, uart_bit_timer: a loadable down-counter with load value and a "period done" pulse. It is reusable by uart_rx later.

Test Plan:
1. L=4, LSB-first, 1 stop, word 8'hA5 → o_tx = 0, then 1,0,1,0,0,1,0,1, then parity 0, then stop 1. Each level lasts 4 clocks (44 clocks total). o_tx_done pulses at clock 45 after accept.
2. L=4, MSB-first, word 8'hA5 → data order 1,0,1,0,0,1,0,1 (bit 7 first), parity 0, same timing.
3. L=3, 2 stops, word 8'h07 → parity 1, frame 36 clocks. L=4 in 1.5 mode → stop high for 6 clocks, frame 46 clocks.
4. Flow control on, i_cts=0, i_tx_valid=1 for 20 clocks → o_tx_ready=0 and o_tx=1 throughout. Raise i_cts → accept in the same cycle, start bit next cycle.
5. Two words 8'h55 and 8'h0F with valid held, L=2 → two correct frames separated by exactly 1 high IDLE clock. Changing i_bit_length to 5 mid-frame has no effect until the second accept.
6. i_bit_length=0 → bits last 1 clock (11-clock frame). Assert i_nrst low during DATA → o_tx=1 immediately, no o_tx_done, next accept produces a clean frame.
